// File: rtl/id_ex_alu_ctrl_pkg.sv
// id_ex_alu_ctrl_pkg: RV32I opcode/funct constants, ALUOp encodings and ID/EX hazard FSM states.
package id_ex_alu_ctrl_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [4:0] ALUOP_ADD   = 5'd0;
  localparam logic [4:0] ALUOP_SUB   = 5'd1;
  localparam logic [4:0] ALUOP_AND   = 5'd2;
  localparam logic [4:0] ALUOP_OR    = 5'd3;
  localparam logic [4:0] ALUOP_XOR   = 5'd4;
  localparam logic [4:0] ALUOP_SLT   = 5'd5;
  localparam logic [4:0] ALUOP_SLL   = 5'd6;
  localparam logic [4:0] ALUOP_SRL   = 5'd7;
  localparam logic [4:0] ALUOP_SRA   = 5'd8;
  localparam logic [4:0] ALUOP_SLLI  = 5'd9;
  localparam logic [4:0] ALUOP_SRLI  = 5'd10;
  localparam logic [4:0] ALUOP_XORI  = 5'd11;
  localparam logic [4:0] ALUOP_ORI   = 5'd12;
  localparam logic [4:0] ALUOP_SLTIU = 5'd13;
  localparam logic [4:0] ALUOP_LUI   = 5'd14;
  localparam logic [4:0] ALUOP_JALR  = 5'd15;
  localparam logic [4:0] ALUOP_BEQ   = 5'd16;
  localparam logic [4:0] ALUOP_BNE   = 5'd17;
  localparam logic [4:0] ALUOP_BLT   = 5'd18;
  localparam logic [4:0] ALUOP_BGE   = 5'd19;
  localparam logic [4:0] ALUOP_BLTU  = 5'd20;
  localparam logic [4:0] ALUOP_BGEU  = 5'd21;
  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;
endpackage

// File: rtl/id_ex_alu_ctrl_alu_op_decode.sv
// alu_op_decode: combinational RV32I instr -> ALUOp, B operand, controls and rs usage.
// ALU_UNSIGNED_BRANCH_EN enables bltu/bgeu decode; otherwise they are illegal.
module alu_op_decode
  import id_ex_alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [OPW-1:0]  o_op,
  output logic [XLEN-1:0] o_b,
  output logic            o_reg_we,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic            o_illegal,
  output logic            o_use_rs1,
  output logic            o_use_rs2
);
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_i_imm;
  logic [XLEN-1:0] w_s_imm;
  logic [XLEN-1:0] w_u_imm;
  logic [XLEN-1:0] w_shamt_imm;
  logic [XLEN-1:0] w_shamt_reg;
  logic            w_shift;
  logic [OPW-1:0]  w_op;
  logic [XLEN-1:0] w_b;
  logic            w_we;
  logic            w_mr;
  logic            w_mw;
  logic            w_ill;
  assign w_opc       = i_instr[6:0];
  assign w_f3        = i_instr[14:12];
  assign w_f7        = i_instr[31:25];
  assign w_i_imm     = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_s_imm     = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_u_imm     = {{(XLEN-32){1'b0}}, i_instr[31:12], 12'b0};
  assign w_shamt_imm = {{(XLEN-5){1'b0}}, i_instr[24:20]};
  assign w_shamt_reg = {{(XLEN-5){1'b0}}, i_rs2_data[4:0]};
  assign w_shift     = (w_f3 == F3_SLL) || (w_f3 == F3_SR);
  always_comb begin
    w_op  = ALUOP_ADD;
    w_b   = i_rs2_data;
    w_we  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_ill = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_we = 1'b1;
        w_b  = w_shift ? w_shamt_reg : i_rs2_data;
        case ({w_f7, w_f3})
          {F7_BASE, F3_ADD}: w_op = ALUOP_ADD;
          {F7_ALT,  F3_ADD}: w_op = ALUOP_SUB;
          {F7_BASE, F3_AND}: w_op = ALUOP_AND;
          {F7_BASE, F3_OR}:  w_op = ALUOP_OR;
          {F7_BASE, F3_XOR}: w_op = ALUOP_XOR;
          {F7_BASE, F3_SLT}: w_op = ALUOP_SLT;
          {F7_BASE, F3_SLL}: w_op = ALUOP_SLL;
          {F7_BASE, F3_SR}:  w_op = ALUOP_SRL;
          {F7_ALT,  F3_SR}:  w_op = ALUOP_SRA;
          default:           w_ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_we = 1'b1;
        w_b  = w_shift ? w_shamt_imm : w_i_imm;
        case (w_f3)
          F3_ADD:  w_op = ALUOP_ADD;
          F3_AND:  w_op = ALUOP_AND;
          F3_OR:   w_op = ALUOP_ORI;
          F3_XOR:  w_op = ALUOP_XORI;
          F3_SLT:  w_op = ALUOP_SLT;
          F3_SLTU: w_op = ALUOP_SLTIU;
          F3_SLL: begin
            w_op  = ALUOP_SLLI;
            w_ill = (w_f7 != F7_BASE);
          end
          default: begin
            w_op  = (w_f7 == F7_ALT) ? ALUOP_SRA : ALUOP_SRLI;
            w_ill = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        w_op = ALUOP_LUI;
        w_b  = w_u_imm;
        w_we = 1'b1;
      end
      OPC_LOAD: begin
        w_b  = w_i_imm;
        w_we = 1'b1;
        w_mr = 1'b1;
      end
      OPC_STORE: begin
        w_b  = w_s_imm;
        w_mw = 1'b1;
      end
      OPC_JALR: begin
        w_op = ALUOP_JALR;
        w_b  = w_i_imm;
        w_we = 1'b1;
      end
      OPC_BRANCH: begin
        case (w_f3)
          F3_BEQ:  w_op = ALUOP_BEQ;
          F3_BNE:  w_op = ALUOP_BNE;
          F3_BLT:  w_op = ALUOP_BLT;
          F3_BGE:  w_op = ALUOP_BGE;
`ifdef ALU_UNSIGNED_BRANCH_EN
          F3_BLTU: w_op = ALUOP_BLTU;
          F3_BGEU: w_op = ALUOP_BGEU;
`endif
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end
  // Illegal encodings must never commit state, and x0 is never written.
  assign o_op      = w_ill ? ALUOP_ADD : w_op;
  assign o_b       = w_b;
  assign o_reg_we  = w_we && !w_ill && (i_instr[11:7] != 5'd0);
  assign o_mem_rd  = w_mr && !w_ill;
  assign o_mem_wr  = w_mw && !w_ill;
  assign o_illegal = w_ill;
  assign o_use_rs1 = (w_opc != OPC_LUI);
  assign o_use_rs2 = (w_opc == OPC_OP) || (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH);
endmodule

// File: rtl/id_ex_alu_ctrl.sv
// id_ex_alu_ctrl: ID/EX pipeline register with load-use bubble FSM, EX hold and flush.
// Build option ALU_UNSIGNED_BRANCH_EN (in alu_op_decode) adds bltu/bgeu.
module id_ex_alu_ctrl
  import id_ex_alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [OPW-1:0]  ex_ALUOp,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [XLEN-1:0] ex_rs2_fwd,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);
  logic [OPW-1:0]  w_op;
  logic [XLEN-1:0] w_b;
  logic            w_we;
  logic            w_mr;
  logic            w_mw;
  logic            w_ill;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_load_use;
  logic            w_cap;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [OPW-1:0]  r_op;
  logic [4:0]      r_rd;
  logic            r_we;
  logic            r_mr;
  logic            r_mw;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_pc;
  logic            r_ill;
  alu_op_decode #(.XLEN(XLEN), .OPW(OPW)) u_dec (
    .i_instr   (id_instr),
    .i_rs2_data(id_rs2_data),
    .o_op      (w_op),
    .o_b       (w_b),
    .o_reg_we  (w_we),
    .o_mem_rd  (w_mr),
    .o_mem_wr  (w_mw),
    .o_illegal (w_ill),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );
  // A load in EX whose rd feeds the instruction in ID cannot be forwarded in time.
  assign w_load_use = (r_state == ST_RUN) && r_valid && r_mr && (r_rd != 5'd0) &&
                      ((w_use_rs1 && (r_rd == id_instr[19:15])) ||
                       (w_use_rs2 && (r_rd == id_instr[24:20])));
  assign w_cap    = !flush && !ex_hold && !w_load_use;
  assign id_stall = !flush && (ex_hold || w_load_use);
  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = ST_RUN;
    else if (!ex_hold)
      w_state_nxt = w_load_use ? ST_BUBBLE : ST_RUN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_valid <= 1'b0;
    else if (flush || (!ex_hold && w_load_use))
      r_valid <= 1'b0;
    else if (w_cap)
      r_valid <= id_valid;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= ALUOP_ADD;
      r_rd  <= '0;
      r_we  <= 1'b0;
      r_mr  <= 1'b0;
      r_mw  <= 1'b0;
      r_rs2 <= '0;
      r_pc  <= '0;
      r_ill <= 1'b0;
    end else if (w_cap) begin
      r_a   <= id_rs1_data;
      r_b   <= w_b;
      r_op  <= w_op;
      r_rd  <= id_instr[11:7];
      r_we  <= w_we;
      r_mr  <= w_mr;
      r_mw  <= w_mw;
      r_rs2 <= id_rs2_data;
      r_pc  <= id_pc;
      r_ill <= w_ill;
    end
  end
  assign ex_valid   = r_valid;
  assign ex_A       = r_a;
  assign ex_B       = r_b;
  assign ex_ALUOp   = r_op;
  assign ex_rd      = r_rd;
  assign ex_reg_we  = r_we;
  assign ex_mem_rd  = r_mr;
  assign ex_mem_wr  = r_mw;
  assign ex_rs2_fwd = r_rs2;
  assign ex_pc      = r_pc;
  assign ex_illegal = r_ill;
endmodule
